// File: rtl/kb_pkg.sv
// Shared types and scancode constants for the keyboard injection path.
// ps2_evt_t matches the 11-bit HPS_IO ps2_key layout bit for bit.
package kb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StHold,
    StRelease,
    StGap
  } inj_state_t;

  typedef struct packed {
    logic       tgl;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;

endpackage

// File: rtl/key_inject_fifo.sv
// Synchronous FIFO for queued scancodes. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate occupancy counter.
module key_inject_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a push while full is accepted alongside it.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/key_inject.sv
// Merges live PS/2 events with queued autotype scancodes into one toggle-signalled stream.
// Live events always take the output slot; injected keys become press/hold/release/gap.
module key_inject
  import kb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HOLD_CYC   = 1_000_000,
  parameter int unsigned GAP_CYC    = 1_000_000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key_in,
  input  logic        inj_wr,
  input  logic [8:0]  inj_data,
  input  logic        inj_abort,
  output logic        inj_full,
  output logic        inj_busy,
  output logic [10:0] ps2_key_out
);

  localparam int unsigned CntMax = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYC - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  inj_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      cur_q, cur_d;
  ps2_evt_t        out_q, out_d;
  logic            live_tgl_q;
  logic            last_evt_q;
  logic            busy_q;

  logic            live_evt;
  logic            slot_free;
  logic            inj_emit;
  logic            inj_pressed;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [8:0]      fifo_dout;

  assign live_evt  = (ps2_key_in[10] != live_tgl_q);
  // Injected events need one quiet cycle after any output event so the matrix sees each toggle.
  assign slot_free = !live_evt && !last_evt_q;
  assign fifo_push = inj_wr && !fifo_full && !inj_abort;

  key_inject_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (inj_abort),
    .din     (inj_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    fifo_pop    = 1'b0;
    inj_emit    = 1'b0;
    inj_pressed = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !inj_abort) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          state_d  = StPress;
        end
      end
      StPress: begin
        if (inj_abort) begin
          state_d = StIdle;
        end else if (slot_free) begin
          inj_emit    = 1'b1;
          inj_pressed = 1'b1;
          cnt_d       = HoldLoad;
          state_d     = StHold;
        end
      end
      StHold: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntOne;
        // Abort still goes through RELEASE so the held key never sticks.
        if (cnt_d == '0 || inj_abort) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (slot_free) begin
          inj_emit = 1'b1;
          cnt_d    = GapLoad;
          state_d  = StGap;
        end
      end
      StGap: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntOne;
        if (cnt_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (live_evt) begin
      out_d = {~out_q.tgl, ps2_key_in[9:0]};
    end else if (inj_emit) begin
      out_d.tgl     = ~out_q.tgl;
      out_d.pressed = inj_pressed;
      out_d.ext     = cur_q[8];
      out_d.code    = cur_q[7:0];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cur_q      <= '0;
      out_q      <= '0;
      live_tgl_q <= 1'b0;
      last_evt_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      out_q      <= out_d;
      live_tgl_q <= ps2_key_in[10];
      last_evt_q <= live_evt || inj_emit;
      busy_q     <= !fifo_empty || (state_q != StIdle);
    end
  end

  assign ps2_key_out = out_q;
  assign inj_full    = fifo_full;
  assign inj_busy    = busy_q;

endmodule
